ram_arbiter_2p: RTL

Two-port round-robin arbiter and sequencer in front of the single-port synchronous RAM (w_r, addr, data_in, data_out).
- Two independent requesters issue read/write commands over valid/ready handshakes.
- The block serialises the commands onto the one RAM port and drives all RAM control.
- Read data returns to the originating requester with a one-cycle response pulse.
- It sits between bus-side masters and the RAM instance and is the only driver of the RAM inputs.

---
 rtl/ram_arbiter_2p.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter_2p.sv
// ============================================================================
// Module   : ram_arbiter_2p
// Purpose  : Round-robin arbiter and sequencer that lets two requesters share
//            one single-port synchronous RAM (registered read, 1-cycle latency).
//            Commands are accepted on valid/ready handshakes. They are issued to
//            the RAM one at a time. Read data returns to the requester that
//            issued the read, with a one-cycle response pulse.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            reqN_valid/ready     - command handshake, N = 0,1
//            reqN_we/addr/wdata   - command fields (we=1 write, we=0 read)
//            rspN_valid/rdata     - read response pulse and held read data
//            ram_w_r/addr/data_in - RAM control, driven only by this block
//            ram_data_out         - RAM read data
//            busy                 - high whenever a command is in flight
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter_2p #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [A_WIDTH-1:0] req0_addr,
  input  logic [D_WIDTH-1:0] req0_wdata,
  output logic               rsp0_valid,
  output logic [D_WIDTH-1:0] rsp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [A_WIDTH-1:0] req1_addr,
  input  logic [D_WIDTH-1:0] req1_wdata,
  output logic               rsp1_valid,
  output logic [D_WIDTH-1:0] rsp1_rdata,
  output logic               ram_w_r,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [D_WIDTH-1:0] ram_data_in,
  input  logic [D_WIDTH-1:0] ram_data_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic   r_last_grant;   // requester that won the most recent accept
  logic   r_id;           // requester that owns the in-flight command
  logic   w_grant0;
  logic   w_grant1;
  logic   w_accept;
  logic   w_sel;          // 1 = requester 1 is being accepted

  // On a tie the requester that did not win last time is granted.
  assign w_grant0 = req0_valid && (!req1_valid ||  r_last_grant);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

  assign req0_ready = (r_state == S_IDLE) && w_grant0;
  assign req1_ready = (r_state == S_IDLE) && w_grant1;

  assign w_accept = req0_ready || req1_ready;
  assign w_sel    = req1_ready;

  assign busy = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. In ACCESS, ram_w_r still holds the accepted command's
  // write flag, so it decides whether a capture cycle is needed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next = ram_w_r ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command launch, grant history and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_w_r      <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      // Write enable is only ever high for the single ACCESS cycle.
      ram_w_r    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;

      if (w_accept) begin
        ram_w_r      <= w_sel ? req1_we    : req0_we;
        ram_addr     <= w_sel ? req1_addr  : req0_addr;
        ram_data_in  <= w_sel ? req1_wdata : req0_wdata;
        r_id         <= w_sel;
        r_last_grant <= w_sel;
      end

      if (r_state == S_CAPTURE) begin
        if (r_id) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= ram_data_out;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= ram_data_out;
        end
      end
    end
  end

endmodule

`default_nettype wire
